// File: rtl/up_down_counter_param.sv
// Parametrised up/down counter: programmable modulus, enable, clamped parallel load,
// wrap/saturate overflow, terminal count and wrap pulse. Optional wrap event counter: UDC_WRAP_COUNT_EN.
module up_down_counter_param #(
  parameter int unsigned      WIDTH   = 4,
  parameter longint unsigned  MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             M,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             sat,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic [7:0]       wrap_cnt
);

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic             wrap_r;
  logic             wrap_next;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   d_ext;
  logic [WIDTH:0]   q_inc;
  logic [WIDTH:0]   q_dec;

  assign q_ext = {1'b0, q_r};
  assign d_ext = {1'b0, d};
  assign q_inc = q_ext + 1'b1;
  assign q_dec = q_ext - 1'b1;

  always_comb begin
    q_next    = q_r;
    wrap_next = 1'b0;
    if (load) begin
      q_next = (d_ext > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : d;
    end else if (en) begin
      if (M) begin
        if (q_ext < MAX_EXT) begin
          q_next = q_inc[WIDTH-1:0];
        end else if (!sat) begin
          q_next    = '0;
          wrap_next = 1'b1;
        end
      end else begin
        if (q_ext != '0) begin
          q_next = q_dec[WIDTH-1:0];
        end else if (!sat) begin
          q_next    = MAX_EXT[WIDTH-1:0];
          wrap_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_next;
      wrap_r <= wrap_next;
    end
  end

  assign q    = q_r;
  assign wrap = wrap_r;
  assign tc   = (M && (q_ext == MAX_EXT)) || (!M && (q_ext == '0));

`ifdef UDC_WRAP_COUNT_EN
  logic [7:0] wcnt_r;

  // Counts on the same edge that sets wrap, so wrap_cnt stays aligned with the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_r <= '0;
    end else if (wrap_next && (wcnt_r != 8'hFF)) begin
      wcnt_r <= wcnt_r + 8'd1;
    end
  end

  assign wrap_cnt = wcnt_r;
`else
  assign wrap_cnt = '0;
`endif

endmodule

// File: tb/tb_up_down_counter_param.sv
// Directed table-driven bench for up_down_counter_param with WIDTH=4, MAX_VAL=9.
module tb_up_down_counter_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       M = 1'b0;
  logic       load = 1'b0;
  logic [3:0] d = '0;
  logic       sat = 1'b0;
  logic [3:0] q;
  logic       tc;
  logic       wrap;
  logic [7:0] wrap_cnt;

`ifdef UDC_WRAP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  up_down_counter_param #(.WIDTH(4), .MAX_VAL(9)) dut (
    .clk(clk), .reset(reset), .en(en), .M(M), .load(load), .d(d), .sat(sat),
    .q(q), .tc(tc), .wrap(wrap), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       ld;
    bit       en;
    bit       m;
    bit       sat;
    bit [3:0] d;
    bit [3:0] q;
    bit       tc;
    bit       wrap;
    int       wcnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(bit rst_i, bit ld_i, bit en_i, bit m_i, bit sat_i, bit [3:0] d_i,
                     bit [3:0] q_i, bit tc_i, bit wrap_i, int wcnt_i);
    vec_t v;
    v.rst = rst_i; v.ld = ld_i; v.en = en_i; v.m = m_i; v.sat = sat_i; v.d = d_i;
    v.q = q_i; v.tc = tc_i; v.wrap = wrap_i; v.wcnt = wcnt_i;
    vecs.push_back(v);
  endtask

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(bit rst_i, bit ld_i, bit en_i, bit m_i, bit sat_i, bit [3:0] d_i);
    reset = rst_i; load = ld_i; en = en_i; M = m_i; sat = sat_i; d = d_i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst ld en M sat d  ->  q tc wrap wrap_cnt(when counting enabled)
    add(1, 0, 1, 1, 0, 0,   0, 0, 0, 0);
    for (int unsigned i = 1; i <= 9; i++)
      add(0, 0, 1, 1, 0, 0,   4'(i), (i == 9), 0, 0);
    add(0, 0, 1, 1, 0, 0,   0, 0, 1, 1);   // up wrap 9 -> 0
    add(0, 0, 1, 0, 0, 0,   9, 0, 1, 2);   // down wrap 0 -> 9
    add(0, 1, 0, 0, 0, 0,   0, 1, 0, 2);
    add(0, 0, 1, 0, 1, 0,   0, 1, 0, 2);   // down saturate at 0
    add(0, 0, 1, 0, 1, 0,   0, 1, 0, 2);
    add(0, 1, 0, 1, 0, 13,  9, 1, 0, 2);   // load clamp
    add(0, 1, 1, 1, 0, 5,   5, 0, 0, 2);   // load beats en
    add(0, 0, 1, 1, 0, 0,   6, 0, 0, 2);
    add(0, 0, 1, 1, 0, 0,   7, 0, 0, 2);
    add(0, 0, 1, 1, 0, 0,   8, 0, 0, 2);
    add(0, 0, 1, 0, 0, 0,   7, 0, 0, 2);   // direction change, no stall
    add(0, 0, 1, 0, 0, 0,   6, 0, 0, 2);
    add(0, 0, 1, 0, 0, 0,   5, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0,   5, 0, 0, 2);   // hold
    add(0, 1, 0, 1, 0, 9,   9, 1, 0, 2);
    add(0, 0, 1, 1, 1, 0,   9, 1, 0, 2);   // up saturate at 9
    add(1, 1, 1, 1, 0, 7,   0, 0, 0, 0);   // reset beats wrap step and load
    add(0, 1, 0, 0, 0, 15,  9, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,   8, 0, 0, 0);

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].en, vecs[i].m, vecs[i].sat, vecs[i].d);
      chk($sformatf("v%0d_q", i), int'(q), int'(vecs[i].q));
      chk($sformatf("v%0d_tc", i), int'(tc), int'(vecs[i].tc));
      chk($sformatf("v%0d_wrap", i), int'(wrap), int'(vecs[i].wrap));
      chk($sformatf("v%0d_wrap_cnt", i), int'(wrap_cnt), CNT_EN ? vecs[i].wcnt : 0);
    end

    // 300 consecutive up-wraps: load 9 then step up each time
    drive(1, 0, 0, 1, 0, 0);
    for (int unsigned i = 1; i <= 300; i++) begin
      drive(0, 1, 0, 1, 0, 9);
      drive(0, 0, 1, 1, 0, 0);
      if (i == 10 || i == 254 || i == 255 || i == 300) begin
        chk($sformatf("wraps%0d_q", i), int'(q), 0);
        chk($sformatf("wraps%0d_wrap", i), int'(wrap), 1);
        chk($sformatf("wraps%0d_wrap_cnt", i), int'(wrap_cnt),
            CNT_EN ? ((i > 255) ? 255 : int'(i)) : 0);
      end
    end
    // load does not clear the count; reset does
    drive(0, 1, 0, 1, 0, 3);
    chk("load_keeps_wrap_cnt", int'(wrap_cnt), CNT_EN ? 255 : 0);
    chk("load_wrap_low", int'(wrap), 0);
    drive(1, 0, 0, 1, 0, 0);
    chk("reset_clears_wrap_cnt", int'(wrap_cnt), 0);
    chk("reset_q", int'(q), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
